gemm_accelerator_top: RTL and testbench
=======================================

GEMM_ACCELERATOR_TOP -- requirements
Module: gemm_accelerator_top

Interface
REQ-001 Parameters SHALL be (name, default, meaning): InDataWidth 8 (signed A/B element width); OutDataWidth 32 (signed C element width); AddrWidth 12 (SRAM word address width); SizeAddrWidth 8 (matrix dimension width).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start_i, input, 1 bit: start request, sampled only in IDLE.
REQ-006 Ports M_size_i, K_size_i, N_size_i, input, SizeAddrWidth each: matrix dimensions M, K, N.
REQ-007 Ports sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, output, AddrWidth each: word addresses into the A, B and C memories.
REQ-008 Ports sram_a_rdata_i, sram_b_rdata_i, input, InDataWidth each: signed read data from A and B.
REQ-009 Port sram_c_wdata_o, output, OutDataWidth: signed result word written to C.
REQ-010 Port sram_c_we_o, output, 1 bit: C write enable.
REQ-011 Port done_o, output, 1 bit: completion pulse.

Function
REQ-012 The A, B and C memories SHALL be external single-port SRAMs (multi_port_memory with one port) with 1-cycle registered read latency: data for the address presented in cycle t appears in cycle t+1. A C write SHALL take effect at the rising edge where sram_c_we_o=1.
REQ-013 Memory layout SHALL be row-major: A[m][k] at m*K+k, B[k][n] at k*N+n, C[m][n] at m*N+n, all starting at address 0.
REQ-014 The block SHALL compute C = A x B with a single multiply-accumulate unit.
REQ-015 Each product SHALL be signed 8x8 -> 16 bits, sign-extended and accumulated in a 32-bit two's-complement register that wraps on overflow.
REQ-016 The FSM states SHALL be IDLE, BUSY, FINISH and DONE.
REQ-017 IDLE -> BUSY SHALL occur when start_i=1. At that edge M, K and N are latched, and all counters and the accumulator are cleared.
REQ-018 In BUSY, each cycle SHALL issue one (m,n,k) address pair, with k innermost, then n, then m.
REQ-019 In BUSY, addresses SHALL be combinational from the counters. After the last triple (m=M-1, n=N-1, k=K-1) is issued, the FSM SHALL go to FINISH.
REQ-020 A 1-cycle-delayed valid/last/C-address pipeline SHALL track the issued addresses.
REQ-021 When valid data for k<K-1 returns, acc SHALL become acc + product.
REQ-022 When valid data for k=K-1 returns, the block SHALL drive sram_c_we_o=1, sram_c_wdata_o=acc+product and sram_c_addr_o=m*N+n, and clear acc.
REQ-023 FINISH SHALL last one cycle and carry the final write. DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-024 Latency: done_o SHALL be high exactly M*N*K+2 cycles after the start edge. Exactly M*N C writes SHALL occur.
REQ-025 If M, K or N is 0, the FSM SHALL go IDLE -> DONE directly, with no memory writes.
REQ-026 start_i outside IDLE SHALL be ignored. Size inputs SHALL only be sampled at start.
REQ-027 Address arithmetic SHALL be AddrWidth bits and truncate modulo 2^AddrWidth. Callers keep M*K, K*N and M*N at most 4096.
REQ-028 Outside write cycles, sram_c_we_o SHALL be 0; sram_c_wdata_o and sram_c_addr_o are don't-care.
REQ-029 A back-to-back start SHALL be accepted in the cycle after DONE.

Reset
REQ-030 While rst_ni=0, the block SHALL immediately enter IDLE and force these values: counters, accumulator and pipeline = 0; sram_c_we_o = 0; done_o = 0; addresses = 0.
REQ-031 Reset asserted mid-operation SHALL abort the computation with no further C writes. A new start after reset SHALL produce a correct result.

Verification
REQ-032 M=K=N=1, A[0]=3, B[0]=-4 -> one write C[0]=-12; done_o high 3 cycles after start.
REQ-033 M=2, K=3, N=2, A=[1 2 3;4 5 6], B=[1 2;3 4;5 6] -> C=[22 28;49 64] at addresses 0..3; done 14 cycles after start.
REQ-034 M=K=N=8, all A=127, all B=-128 -> all 64 C words = -130048; exactly 64 writes.
REQ-035 Ten runs with random M, K, N in 1..32 and random int8 data -> C matches the software golden GEMM word-for-word.
REQ-036 Reset pulsed mid-run in an 8x8x8 job -> we and done drop at once; a restarted 2x3x2 job gives REQ-033 results.
REQ-037 start_i held high throughout a run, then M=0 -> single run, no restart; the M=0 job gives done in 1 cycle with no writes.

Source files
------------

// File: rtl/gemm_accelerator_top.sv
// GEMM accelerator: computes C = A x B with one signed multiply-accumulate
// unit. Operands stream from external single-port SRAMs with a one-cycle read
// latency. Results are written to a C SRAM in row-major order.
module gemm_accelerator_top #(
    parameter int unsigned InDataWidth   = 8,
    parameter int unsigned OutDataWidth  = 32,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [SizeAddrWidth-1:0]       M_size_i,
    input  logic [SizeAddrWidth-1:0]       K_size_i,
    input  logic [SizeAddrWidth-1:0]       N_size_i,
    output logic [AddrWidth-1:0]           sram_a_addr_o,
    output logic [AddrWidth-1:0]           sram_b_addr_o,
    output logic [AddrWidth-1:0]           sram_c_addr_o,
    input  logic signed [InDataWidth-1:0]  sram_a_rdata_i,
    input  logic signed [InDataWidth-1:0]  sram_b_rdata_i,
    output logic signed [OutDataWidth-1:0] sram_c_wdata_o,
    output logic                           sram_c_we_o,
    output logic                           done_o
);

    localparam logic [SizeAddrWidth-1:0] SizeOne = SizeAddrWidth'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                          state_q;
    logic [SizeAddrWidth-1:0]        m_q;
    logic [SizeAddrWidth-1:0]        n_q;
    logic [SizeAddrWidth-1:0]        k_q;
    logic [SizeAddrWidth-1:0]        m_size_q;
    logic [SizeAddrWidth-1:0]        k_size_q;
    logic [SizeAddrWidth-1:0]        n_size_q;
    logic                            done_q;

    // Issue-to-return tracking: one stage matches the SRAM read latency.
    logic                            vld_p1;
    logic                            last_p1;
    logic [AddrWidth-1:0]            caddr_p1;
    logic signed [OutDataWidth-1:0]  acc_q;

    logic                            size_zero;
    logic                            busy;
    logic                            k_last;
    logic                            n_last;
    logic                            m_last;
    logic signed [OutDataWidth-1:0]  mac_sum;

    // Row-major word address row*stride+col, wrapping modulo 2^AddrWidth.
    function automatic logic [AddrWidth-1:0] row_major(
        input logic [SizeAddrWidth-1:0] row,
        input logic [SizeAddrWidth-1:0] stride,
        input logic [SizeAddrWidth-1:0] col
    );
        logic [AddrWidth-1:0] r;
        logic [AddrWidth-1:0] s;
        logic [AddrWidth-1:0] c;
        r = AddrWidth'(row);
        s = AddrWidth'(stride);
        c = AddrWidth'(col);
        return r * s + c;
    endfunction

    // Full-precision signed product, sign-extended and added with wraparound.
    function automatic logic signed [OutDataWidth-1:0] mac(
        input logic signed [OutDataWidth-1:0] acc,
        input logic signed [InDataWidth-1:0]  a,
        input logic signed [InDataWidth-1:0]  b
    );
        logic signed [2*InDataWidth-1:0] prod;
        prod = a * b;
        return acc + OutDataWidth'(prod);
    endfunction

    assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign busy      = (state_q == BUSY);
    assign k_last    = (k_q == k_size_q - SizeOne);
    assign n_last    = (n_q == n_size_q - SizeOne);
    assign m_last    = (m_q == m_size_q - SizeOne);
    assign mac_sum   = mac(acc_q, sram_a_rdata_i, sram_b_rdata_i);

    // Operand addresses follow the loop counters only while issuing.
    assign sram_a_addr_o  = busy ? row_major(m_q, k_size_q, k_q) : '0;
    assign sram_b_addr_o  = busy ? row_major(k_q, n_size_q, n_q) : '0;

    // The write happens in the cycle the last partial product of a C element returns.
    assign sram_c_we_o    = vld_p1 & last_p1;
    assign sram_c_wdata_o = mac_sum;
    assign sram_c_addr_o  = sram_c_we_o ? caddr_p1 : '0;
    assign done_o         = done_q;

    // Control FSM: latches sizes at start and steps k, then n, then m.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            m_size_q <= '0;
            k_size_q <= '0;
            n_size_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        m_size_q <= M_size_i;
                        k_size_q <= K_size_i;
                        n_size_q <= N_size_i;
                        m_q      <= '0;
                        n_q      <= '0;
                        k_q      <= '0;
                        if (size_zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (k_last) begin
                        k_q <= '0;
                        if (n_last) begin
                            n_q <= '0;
                            if (m_last) begin
                                state_q <= FINISH;
                            end else begin
                                m_q <= m_q + SizeOne;
                            end
                        end else begin
                            n_q <= n_q + SizeOne;
                        end
                    end else begin
                        k_q <= k_q + SizeOne;
                    end
                end
                FINISH: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Return pipeline and accumulator: sum partial products, clear after each C write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            caddr_p1 <= '0;
            acc_q    <= '0;
        end else begin
            // stage p0 -> p1: issued triple becomes returning data
            vld_p1   <= busy;
            last_p1  <= k_last;
            caddr_p1 <= row_major(m_q, n_size_q, n_q);
            if ((state_q == IDLE) && start_i) begin
                acc_q <= '0;
            end else if (vld_p1) begin
                acc_q <= last_p1 ? '0 : mac_sum;
            end
        end
    end

endmodule

// File: tb/tb_gemm_accelerator_top.sv
module tb_gemm_accelerator_top;

    localparam int LIMIT = 40000;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [7:0]         m_sz;
    logic [7:0]         k_sz;
    logic [7:0]         n_sz;
    logic [11:0]        a_addr;
    logic [11:0]        b_addr;
    logic [11:0]        c_addr;
    logic signed [7:0]  a_rdata;
    logic signed [7:0]  b_rdata;
    logic signed [31:0] c_wdata;
    logic               c_we;
    logic               done;

    logic signed [7:0]  a_mem [0:4095];
    logic signed [7:0]  b_mem [0:4095];
    logic signed [31:0] c_mem [0:4095];
    int                 c_epoch [0:4095];
    int                 epoch;
    int                 wr_cnt;
    int                 checks;
    int                 errors;

    gemm_accelerator_top dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .M_size_i       (m_sz),
        .K_size_i       (k_sz),
        .N_size_i       (n_sz),
        .sram_a_addr_o  (a_addr),
        .sram_b_addr_o  (b_addr),
        .sram_c_addr_o  (c_addr),
        .sram_a_rdata_i (a_rdata),
        .sram_b_rdata_i (b_rdata),
        .sram_c_wdata_o (c_wdata),
        .sram_c_we_o    (c_we),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_cnt = 0;
        for (int i = 0; i < 4096; i++) c_epoch[i] = 0;
    end

    // SRAM models: registered reads, writes at the clock edge with we high
    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr];
        b_rdata <= b_mem[b_addr];
        if (c_we === 1'b1) begin
            c_mem[c_addr]   <= c_wdata;
            c_epoch[c_addr] <= epoch;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    // Starts a job and returns the number of edges until done (start edge = 1), -1 on timeout.
    task automatic run_job(input int m, input int k, input int n, output int lat);
        epoch = epoch + 1;
        m_sz  = 8'(m);
        k_sz  = 8'(k);
        n_sz  = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic load_233();
        int av [6];
        int bv [6];
        av = '{1, 2, 3, 4, 5, 6};
        bv = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 6; i++) begin
            a_mem[i] = 8'(av[i]);
            b_mem[i] = 8'(bv[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_sz  = '0;
        k_sz  = '0;
        n_sz  = '0;
        epoch = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({c_we, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: we/done=%b required 00", {c_we, done});
        end
        checks++;
        if ({a_addr, b_addr, c_addr} !== 36'd0) begin
            errors++;
            $display("FAIL reset_addr: a=%0h b=%0h c=%0h required 0", a_addr, b_addr, c_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat;
        int w0;
        a_mem[0] = 8'sd3;
        b_mem[0] = -8'sd4;
        w0 = wr_cnt;
        run_job(1, 1, 1, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d required 3", lat);
        end
        checks++;
        if (c_mem[0] !== -32'sd12 || c_epoch[0] != epoch) begin
            errors++;
            $display("FAIL single_result: got %0d required -12", c_mem[0]);
        end
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL single_writes: got %0d required 1", wr_cnt - w0);
        end
    endtask

    task automatic test_small();
        int lat;
        int w0;
        int exp_c [4];
        exp_c = '{22, 28, 49, 64};
        load_233();
        w0 = wr_cnt;
        run_job(2, 3, 2, lat);
        checks++;
        if (lat != 14) begin
            errors++;
            $display("FAIL small_latency: got %0d required 14", lat);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_mem[i] !== exp_c[i] || c_epoch[i] != epoch) begin
                errors++;
                $display("FAIL small_c%0d: got %0d required %0d", i, c_mem[i], exp_c[i]);
            end
        end
        checks++;
        if (wr_cnt - w0 != 4) begin
            errors++;
            $display("FAIL small_writes: got %0d required 4", wr_cnt - w0);
        end
    endtask

    task automatic test_extreme();
        int lat;
        int w0;
        int bad;
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = 8'sd127;
            b_mem[i] = -8'sd128;
        end
        w0 = wr_cnt;
        run_job(8, 8, 8, lat);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (c_mem[i] !== -32'sd130048 || c_epoch[i] != epoch) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL extreme_values: %0d wrong words, c[0]=%0d required -130048", bad, c_mem[0]);
        end
        checks++;
        if (wr_cnt - w0 != 64 || lat != 514) begin
            errors++;
            $display("FAIL extreme_writes: writes %0d lat %0d required 64 and 514", wr_cnt - w0, lat);
        end
    endtask

    task automatic test_random();
        int m, k, n, lat, w0, bad, exp_v, first_bad;
        for (int run = 0; run < 10; run++) begin
            do begin
                m = $urandom_range(1, 32);
                k = $urandom_range(1, 32);
                n = $urandom_range(1, 32);
            end while (m * k * n > 6000);
            for (int i = 0; i < m * k; i++) a_mem[i] = 8'($urandom);
            for (int i = 0; i < k * n; i++) b_mem[i] = 8'($urandom);
            w0 = wr_cnt;
            run_job(m, k, n, lat);
            bad = 0;
            first_bad = -1;
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    exp_v = 0;
                    for (int kk = 0; kk < k; kk++)
                        exp_v += int'(a_mem[i * k + kk]) * int'(b_mem[kk * n + j]);
                    if (c_mem[i * n + j] !== exp_v || c_epoch[i * n + j] != epoch) begin
                        bad++;
                        if (first_bad < 0) first_bad = i * n + j;
                    end
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random%0d_data (M=%0d K=%0d N=%0d): %0d wrong words, first at %0d", run, m, k, n, bad, first_bad);
            end
            checks++;
            if (lat != m * n * k + 2 || wr_cnt - w0 != m * n) begin
                errors++;
                $display("FAIL random%0d_timing: lat %0d writes %0d required %0d and %0d", run, lat, wr_cnt - w0, m * n * k + 2, m * n);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int w0;
        int lat;
        int exp_c [4];
        exp_c = '{22, 28, 49, 64};
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = 8'($urandom);
            b_mem[i] = 8'($urandom);
        end
        epoch = epoch + 1;
        m_sz  = 8'd8;
        k_sz  = 8'd8;
        n_sz  = 8'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (c_we !== 1'b1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c_we, done} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_drop: we/done=%b required 00", {c_we, done});
        end
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != w0 || a_addr !== 12'd0) begin
            errors++;
            $display("FAIL midreset_quiet: writes %0d a_addr %0h required 0 and 0", wr_cnt - w0, a_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_233();
        run_job(2, 3, 2, lat);
        checks++;
        if (lat != 14 || wr_cnt - w0 != 4) begin
            errors++;
            $display("FAIL midreset_restart: lat %0d writes %0d required 14 and 4", lat, wr_cnt - w0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_mem[i] !== exp_c[i] || c_epoch[i] != epoch) begin
                errors++;
                $display("FAIL midreset_c%0d: got %0d required %0d", i, c_mem[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_start_held();
        int lat;
        int w0;
        logic [3:0] done_seq;
        load_233();
        w0    = wr_cnt;
        epoch = epoch + 1;
        m_sz  = 8'd2;
        k_sz  = 8'd3;
        n_sz  = 8'd2;
        start = 1'b1;
        @(posedge clk); #1;
        m_sz = 8'd0;
        lat  = 1;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 14 || wr_cnt - w0 != 4 || c_mem[3] !== 32'sd64) begin
            errors++;
            $display("FAIL held_first_run: lat %0d writes %0d c3 %0d required 14, 4, 64", lat, wr_cnt - w0, c_mem[3]);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 1'b0;
            @(posedge clk); #1;
            done_seq[i] = done;
        end
        checks++;
        if (done_seq !== 4'b0010) begin
            errors++;
            $display("FAIL held_zero_job: done after edges 1..4 = %b required 0100 (lsb first)", done_seq);
        end
        checks++;
        if (wr_cnt - w0 != 4) begin
            errors++;
            $display("FAIL held_zero_writes: got %0d total writes required 4", wr_cnt - w0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_small();
        test_extreme();
        test_random();
        test_reset_midrun();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
